turn_signal_sequencer: RTL
==========================

TURN_SIGNAL_SEQUENCER -- requirements
Module: turn_signal_sequencer

Interface
REQ-001 Parameter LAMPS, default 3, lamps per side; legal range 1..8.
REQ-002 Parameter DIV, default 1, clock cycles per sequence step; legal range 1..2^16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 left  input  1  left turn request, level-sensitive.
REQ-006 right  input  1  right turn request, level-sensitive.
REQ-007 hazard  input  1  hazard request, level-sensitive; overrides left/right.
REQ-008 brake  input  1  brake pedal, level-sensitive.
REQ-009 light  output  2*LAMPS  lamp drive: light[LAMPS+k] = left lamp k, light[k] = right lamp k; k=0 innermost.
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 The FSM SHALL have exactly four states: IDLE, LEFT, RIGHT, HAZARD.
REQ-012 The block SHALL contain a prescaler cnt (0..DIV-1), a step counter step (0..LAMPS) and a hazard phase bit; tick = (cnt == DIV-1).
REQ-013 cnt SHALL be held at 0 in IDLE, SHALL increment each cycle in the other states, and SHALL wrap to 0 on tick.
REQ-014 The request decode SHALL be: hz = hazard; lreq = left & ~right & ~hazard; rreq = right & ~left & ~hazard; left & right without hazard SHALL be no request.
REQ-015 IDLE: hz -> HAZARD (phase=1); lreq -> LEFT (step=1); rreq -> RIGHT (step=1); else stay. The transition SHALL take effect on the next edge, independent of tick.
REQ-016 LEFT/RIGHT: on tick, step SHALL advance 1..LAMPS-1 -> step+1 and LAMPS -> 0 (dark step).
REQ-017 On tick with step == 0: same-direction request still present -> step=1 in the same state; otherwise -> IDLE.
REQ-018 Direction SHALL be latched for the whole sequence; opposite or dropped requests SHALL be ignored until step 0 completes.
REQ-019 hz sampled in LEFT/RIGHT SHALL abort immediately: next state HAZARD, phase=1, cnt=0, step=0.
REQ-020 HAZARD: phase SHALL toggle on each tick; hz low SHALL return to IDLE on the next edge regardless of tick.
REQ-021 Sequencing side lamp k SHALL be lit iff k < step; the non-sequencing side SHALL be dark.
REQ-022 In HAZARD, all 2*LAMPS lamps SHALL equal phase.
REQ-023 When brake is high, every side not currently sequencing SHALL be fully lit (both sides in IDLE); brake SHALL NOT alter HAZARD or the sequencing side.
REQ-024 light SHALL be combinationally decoded from registered state and brake, with no other input paths.
REQ-025 Steady left request, period SHALL be (LAMPS+1)*DIV cycles after the first IDLE->LEFT cycle.

Reset
REQ-026 While reset = 0: state=IDLE, cnt=0, step=0, phase=0, busy=0, light = all zeros (brake ignored).
REQ-027 Reset asserted mid-sequence SHALL clear all state asynchronously without waiting for clk; the first request after release SHALL start from step 1.

Verification
REQ-028 LAMPS=3, DIV=1, left held -> light[5:0] per cycle: 000000, 001000, 011000, 111000, 000000, 001000 ... and busy=1 from the first sequence cycle.
REQ-029 LAMPS=3, DIV=2, right pulsed 1 cycle -> 000001 x2, 000011 x2, 000111 x2, 000000 x2, then IDLE, busy=0.
REQ-030 LAMPS=3, DIV=1, left held, right asserted at step 2 -> sequence completes to 111000, then dark, then IDLE (left&right = no request).
REQ-031 LAMPS=4, DIV=1, brake=1 plus right -> light[7:4]=1111 throughout; light[3:0] sequences 0001, 0011, 0111, 1111, 0000; IDLE with brake -> 11111111.
REQ-032 LAMPS=3, DIV=3, hazard asserted at step 2 of LEFT -> next cycle 111111 for 3 cycles, 000000 for 3 cycles, alternating; hazard dropped -> IDLE next edge, 000000.
REQ-033 reset driven low between clock edges mid-sequence -> light=000000 and busy=0 before the next edge; after release with left held, the next cycle shows step 1.

Source files
------------

// File: rtl/turn_signal_sequencer.sv
// Sequential turn-signal / hazard / brake lamp controller for one vehicle rear.
// A four-state FSM steps an outward-growing lamp bar; lamp drive is decoded from registered state.
module turn_signal_sequencer #(
  parameter int unsigned LAMPS = 3,
  parameter int unsigned DIV   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 left,
  input  logic                 right,
  input  logic                 hazard,
  input  logic                 brake,
  output logic [2*LAMPS-1:0]   light,
  output logic                 busy
);

  localparam int unsigned CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned STEP_W = $clog2(LAMPS + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DIV - 1);
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(LAMPS);
  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
  localparam logic [LAMPS-1:0]  ALL_ON   = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEFT   = 2'd1,
    RIGHT  = 2'd2,
    HAZARD = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [STEP_W-1:0]   step, step_nxt;
  logic                phase, phase_nxt;

  logic                tick;
  logic                hz, lreq, rreq, same_req;
  logic [LAMPS-1:0]    seq_mask;
  logic [LAMPS-1:0]    left_lamps, right_lamps;

  // Request decode: hazard wins, simultaneous left+right is no request.
  assign tick = (cnt == CNT_MAX);
  assign hz   = hazard;
  assign lreq = left & ~right & ~hazard;
  assign rreq = right & ~left & ~hazard;
  assign same_req = ((state == LEFT) && lreq) || ((state == RIGHT) && rreq);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      step  <= '0;
      phase <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      step  <= step_nxt;
      phase <= phase_nxt;
    end
  end

  // Next-state: direction is latched until the dark step ends; hazard aborts at once.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    step_nxt  = step;
    phase_nxt = phase;
    case (state)
      IDLE: begin
        cnt_nxt   = '0;
        step_nxt  = '0;
        phase_nxt = 1'b0;
        if (hz) begin
          state_nxt = HAZARD;
          phase_nxt = 1'b1;
        end else if (lreq) begin
          state_nxt = LEFT;
          step_nxt  = STEP_ONE;
        end else if (rreq) begin
          state_nxt = RIGHT;
          step_nxt  = STEP_ONE;
        end
      end
      LEFT, RIGHT: begin
        if (hz) begin
          state_nxt = HAZARD;
          phase_nxt = 1'b1;
          cnt_nxt   = '0;
          step_nxt  = '0;
        end else begin
          cnt_nxt = tick ? '0 : cnt + CNT_W'(1);
          if (tick) begin
            if (step == '0) begin
              if (same_req) begin
                step_nxt = STEP_ONE;
              end else begin
                state_nxt = IDLE;
              end
            end else if (step == STEP_MAX) begin
              step_nxt = '0;
            end else begin
              step_nxt = step + STEP_W'(1);
            end
          end
        end
      end
      HAZARD: begin
        if (!hz) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          phase_nxt = 1'b0;
        end else begin
          cnt_nxt = tick ? '0 : cnt + CNT_W'(1);
          if (tick) begin
            phase_nxt = ~phase;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Lamp decode: bar of step lamps on the active side, brake fills the idle side(s).
  always_comb begin
    seq_mask    = '0;
    left_lamps  = '0;
    right_lamps = '0;
    for (int unsigned k = 0; k < LAMPS; k++) begin
      seq_mask[k] = (STEP_W'(k) < step);
    end
    case (state)
      IDLE: begin
        left_lamps  = brake ? ALL_ON : '0;
        right_lamps = brake ? ALL_ON : '0;
      end
      LEFT: begin
        left_lamps  = seq_mask;
        right_lamps = brake ? ALL_ON : '0;
      end
      RIGHT: begin
        left_lamps  = brake ? ALL_ON : '0;
        right_lamps = seq_mask;
      end
      HAZARD: begin
        left_lamps  = {LAMPS{phase}};
        right_lamps = {LAMPS{phase}};
      end
      default: begin
        left_lamps  = '0;
        right_lamps = '0;
      end
    endcase
  end

  // Lamps stay dark while reset is held, even with brake applied.
  assign light = reset ? {left_lamps, right_lamps} : '0;
  assign busy  = (state != IDLE);

endmodule
